// File: rtl/tmc_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tmc_pio_pkg
// Brief   : Register map and edge-type encodings for the PIO input blocks.
// Revision: 1.0
// ============================================================================
package tmc_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/tmc_sync_bus.sv
`default_nettype none
// ============================================================================
// Module  : tmc_sync_bus
// Brief   : WIDTH x STAGES multi-flop synchroniser, async reset, 0 = bypass.
// Revision: 1.0
// ============================================================================
module tmc_sync_bus #(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      // Input already lives in the clk domain; clock and reset are not needed.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0][WIDTH-1:0] chain;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain <= {STAGES{RESET_VALUE}};
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tmc_nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
// Module  : tmc_nios2_pio_in_edge
// Brief   : Avalon-MM PIO input with sync, edge capture, irq mask and level irq.
// Revision: 1.0
// ============================================================================
module tmc_nios2_pio_in_edge
  import tmc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wd;

  tmc_sync_bus #(
    .WIDTH       (WIDTH),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync)
  );

  assign wr        = chipselect & ~write_n;
  assign rise      = sync & ~prev;
  assign fall      = ~sync & prev;
  assign unused_wd = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: det = fall;
      EDGE_ANY:  det = rise | fall;
      default:   det = rise;
    endcase
  end

  // Upper bits stay zero so narrow configurations read back cleanly.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = sync;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= RESET_VALUE;
    end else begin
      prev <= sync;
    end
  end

  // OR-ing det after the clear lets a coincident new edge win over W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr && address == ADDR_EDGE_CAP) begin
        edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | det;
      end else begin
        edge_capture <= edge_capture | det;
      end
      if (wr && address == ADDR_IRQ_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      readdata <= rd_mux;
      irq      <= |(edge_capture & irq_mask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmc_nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
// Module  : tb_tmc_nios2_pio_in_edge
// Brief   : Directed self-checking bench: rising/falling/any-edge instances.
// Revision: 1.0
// ============================================================================
module tb_tmc_nios2_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_a = '0, in_b = '0, in_c = '0;
  logic [31:0] readdata_a, readdata_b, readdata_c;
  logic        irq_a, irq_b, irq_c;
  logic [31:0] rd_a, rd_b, rd_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmc_nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'h00)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a));

  tmc_nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .RESET_VALUE(8'h00)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b));

  tmc_nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(0), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_c),
    .readdata(readdata_c), .irq(irq_c));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk);
    address = a;
    @(negedge clk);
    rd_a = readdata_a; rd_b = readdata_b; rd_c = readdata_c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    chipselect = 1'b0; write_n = 1'b1; address = '0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (readdata_a !== 32'h0) begin failures++; $display("FAIL reset_readdata: got %h expected %h", readdata_a, 32'h0); end
    checks++; if ({irq_a, irq_b, irq_c} !== 3'b000) begin failures++; $display("FAIL reset_irq: got %b expected %b", {irq_a, irq_b, irq_c}, 3'b000); end
    reset_n = 1'b1;
  endtask

  task automatic test_data();
    in_a = 8'hA5; in_c = 8'h3C;
    tick(3);
    bus_read(2'd0);
    checks++; if (rd_a !== 32'h000000A5) begin failures++; $display("FAIL data_sync: got %h expected %h", rd_a, 32'h000000A5); end
    checks++; if (rd_c !== 32'h0000003C) begin failures++; $display("FAIL data_bypass: got %h expected %h", rd_c, 32'h0000003C); end
    bus_read(2'd1);
    checks++; if (rd_a !== 32'h0) begin failures++; $display("FAIL rsvd_read: got %h expected %h", rd_a, 32'h0); end
  endtask

  task automatic test_rise();
    do_reset();
    tick(3);
    address = 2'd3; in_a = 8'h01; in_b = 8'h01;
    tick(3);
    checks++; if (readdata_a !== 32'h0) begin failures++; $display("FAIL rise_early: got %h expected %h", readdata_a, 32'h0); end
    tick(1);
    checks++; if (readdata_a !== 32'h1) begin failures++; $display("FAIL rise_capture: got %h expected %h", readdata_a, 32'h1); end
    checks++; if (readdata_b !== 32'h0) begin failures++; $display("FAIL fall_ignores_rise: got %h expected %h", readdata_b, 32'h0); end
    in_a = 8'h00; in_b = 8'h00;
    tick(5);
    checks++; if (readdata_a !== 32'h1) begin failures++; $display("FAIL rise_hold: got %h expected %h", readdata_a, 32'h1); end
    checks++; if (readdata_b !== 32'h1) begin failures++; $display("FAIL fall_capture: got %h expected %h", readdata_b, 32'h1); end
  endtask

  task automatic test_mask();
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b expected %b", irq_a, 1'b0); end
    bus_write(2'd2, 32'h1);
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_latency: got %b expected %b", irq_a, 1'b0); end
    tick(1);
    checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL irq_assert: got %b expected %b", irq_a, 1'b1); end
    bus_read(2'd2);
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL mask_readback: got %h expected %h", rd_a, 32'h1); end
    bus_write(2'd2, 32'h0);
    checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b expected %b", irq_a, 1'b1); end
    tick(1);
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_deassert: got %b expected %b", irq_a, 1'b0); end
    bus_read(2'd3);
    checks++; if (rd_a !== 32'h1) begin failures++; $display("FAIL mask_no_ec_effect: got %h expected %h", rd_a, 32'h1); end
  endtask

  task automatic test_w1c_collision();
    do_reset();
    in_a = 8'h03;
    tick(5);
    bus_read(2'd3);
    checks++; if (rd_a !== 32'h3) begin failures++; $display("FAIL w1c_setup: got %h expected %h", rd_a, 32'h3); end
    in_a = 8'h01;
    tick(5);
    in_a = 8'h03;
    tick(1);
    bus_write(2'd3, 32'h3);
    bus_read(2'd3);
    checks++; if (rd_a !== 32'h2) begin failures++; $display("FAIL w1c_set_wins: got %h expected %h", rd_a, 32'h2); end
    bus_write(2'd3, 32'h2);
    bus_read(2'd3);
    checks++; if (rd_a !== 32'h0) begin failures++; $display("FAIL w1c_clear: got %h expected %h", rd_a, 32'h0); end
  endtask

  task automatic test_any_bypass();
    do_reset();
    tick(1);
    address = 2'd3; in_c = 8'h80;
    tick(1);
    checks++; if (readdata_c !== 32'h0) begin failures++; $display("FAIL any_rise_early: got %h expected %h", readdata_c, 32'h0); end
    tick(1);
    checks++; if (readdata_c !== 32'h80) begin failures++; $display("FAIL any_rise: got %h expected %h", readdata_c, 32'h80); end
    bus_write(2'd3, 32'h80);
    tick(1);
    checks++; if (readdata_c !== 32'h0) begin failures++; $display("FAIL any_clear: got %h expected %h", readdata_c, 32'h0); end
    in_c = 8'h00;
    tick(1);
    checks++; if (readdata_c !== 32'h0) begin failures++; $display("FAIL any_fall_early: got %h expected %h", readdata_c, 32'h0); end
    tick(1);
    checks++; if (readdata_c !== 32'h80) begin failures++; $display("FAIL any_fall: got %h expected %h", readdata_c, 32'h80); end
    bus_write(2'd2, 32'hFFFFFF00);
    bus_read(2'd2);
    checks++; if (rd_c !== 32'h0) begin failures++; $display("FAIL mask_upper_ignored: got %h expected %h", rd_c, 32'h0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_a = 8'hFF;
    tick(4);
    bus_write(2'd2, 32'hFF);
    tick(2);
    checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL mid_irq_before: got %b expected %b", irq_a, 1'b1); end
    address = 2'd3;
    reset_n = 1'b0;
    #1;
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL mid_irq_async: got %b expected %b", irq_a, 1'b0); end
    checks++; if (readdata_a !== 32'h0) begin failures++; $display("FAIL mid_rd_async: got %h expected %h", readdata_a, 32'h0); end
    @(negedge clk);
    checks++; if (readdata_a !== 32'h0) begin failures++; $display("FAIL mid_rd_during: got %h expected %h", readdata_a, 32'h0); end
    reset_n = 1'b1;
    tick(1);
    checks++; if (readdata_a !== 32'h0) begin failures++; $display("FAIL mid_ec_cleared: got %h expected %h", readdata_a, 32'h0); end
    bus_read(2'd2);
    checks++; if (rd_a !== 32'h0) begin failures++; $display("FAIL mid_mask_cleared: got %h expected %h", rd_a, 32'h0); end
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL mid_irq_after: got %b expected %b", irq_a, 1'b0); end
    tick(3);
    bus_read(2'd3);
    checks++; if (rd_a !== 32'hFF) begin failures++; $display("FAIL post_reset_redetect: got %h expected %h", rd_a, 32'hFF); end
  endtask

  initial begin
    test_reset();
    test_data();
    test_rise();
    test_mask();
    test_w1c_collision();
    test_any_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tmc_nios2_pio_in_edge.md
Name: tmc_nios2_pio_in_edge

Overview:
- Parametrised Avalon-MM read port for WIDTH-bit input pins, replacing the fixed 1-bit status input ports on the Nios II bus.
- Adds a metastability synchroniser, per-bit edge capture, a per-bit interrupt mask and a level interrupt to the CPU.
- Sits between asynchronous fabric status signals (FIFO flags, trigger lines) and the Nios II data master.

Parameters:
- WIDTH, 8: number of input bits; legal range 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit; 0 = bypass for inputs already in the clk domain; legal range 0..3.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- RESET_VALUE, 0: reset value for the sync chain and the previous-sample register (WIDTH bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  external input pins, asynchronous unless SYNC_STAGES=0
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high

Behaviour:
- Reset is asynchronous and active-low. On assertion, readdata=0, irq=0, irq_mask=0 and edge_capture=0. The sync chain and the prev register both reset to RESET_VALUE.
- Synchroniser: sync = in_port delayed by SYNC_STAGES clocks. With SYNC_STAGES=0, sync = in_port combinationally.
- Edge detection: prev <= sync every cycle.
  - rise = sync & ~prev
  - fall = ~sync & prev
  - det = rise, fall or (rise|fall), selected by EDGE_TYPE.
- Edge capture from a pin change: the edge_capture bit sets SYNC_STAGES+1 cycles after the pin change.
- Register map. All registers are 32 bits; bits above WIDTH read 0 and ignore writes.
  - addr 0 DATA: read-only. Reads sync. Writes are ignored.
  - addr 1: reserved. Reads 0. Writes are ignored.
  - addr 2 IRQ_MASK: read/write. Written when chipselect & ~write_n & address==2.
  - addr 3 EDGE_CAPTURE: read. Write-1-to-clear: edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | det.
- A new edge on a bit in the same cycle as a W1C of that bit leaves the bit set; set wins.
- When not written: edge_capture <= edge_capture | det.
- Read path: readdata <= mux(address) every clock, regardless of chipselect. Read latency is 1 cycle, fixed; the no-wait-state slave ignores waitrequest. Reads have no side effects.
- irq <= |(edge_capture & irq_mask), registered. irq asserts 1 cycle after the capture bit sets. irq deasserts 1 cycle after the clear write or the mask write.
- A mask change affects only irq, never edge_capture. Edges on masked bits are still captured.
- Reset after deassert: if in_port differs from RESET_VALUE, that difference is detected as an edge once the sync chain fills. This is intended behaviour; software clears EDGE_CAPTURE at init.
- Reset asserted mid-operation clears all state immediately. No partial write survives.
- No other states; there is no FSM beyond the capture/clear logic.

Decomposition:
- Package tmc_pio_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- One sub-module is natural: tmc_sync_bus, a WIDTH x SYNC_STAGES synchroniser with async reset to RESET_VALUE and a bypass at 0 stages. It is reused by other input blocks.

Test Plan (all cases use WIDTH=8, SYNC_STAGES=2 unless stated otherwise):
- Reset/data: hold reset_n=0 and check readdata=0, irq=0. Release reset, drive in_port=0xA5, read addr 0 after 3 cycles -> readdata=0x000000A5. Read addr 1 -> 0.
- Rising capture: EDGE_TYPE=0, in_port 0x00->0x01 -> edge_capture=0x01 at cycle +3. Then 0x01->0x00 -> still 0x01. Read addr 3 -> 0x00000001.
- IRQ mask: edge_capture=0x01 and mask=0 -> irq=0. Write mask=0x01 -> irq=1 one cycle later. Write mask=0 -> irq=0 one cycle later.
- W1C collision: edge_capture=0x03. Write 0x03 to addr 3 in the same cycle that det=0x02 -> edge_capture=0x02 afterwards.
- Any-edge and bypass: EDGE_TYPE=2, SYNC_STAGES=0, toggle bit 7 high then low, clearing in between -> bit 7 is captured 1 cycle after each toggle. Write 0xFFFFFF00 to addr 2 -> readback 0x00000000.
- Mid-operation reset: mask=0xFF with irq=1, pulse reset_n low for 1 cycle -> irq=0, mask=0 and edge_capture=0 immediately; readdata=0 during reset.
